// File: rtl/inst_loader.sv
// inst_loader: program loader for the Inst_mem load port.
// Accepts a byte stream (2-byte little-endian word count, then count words
// sent LSB first), writes the words into instruction memory starting at
// address 0, zero-fills the remaining words, waits HOLD_CYCLES, then releases
// the CPU reset so the core fetches from address 0.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            one-cycle load request (honoured in IDLE and RUN)
//   byte_valid/data  incoming stream byte
//   byte_ready       loader accepts a byte this cycle
//   mem_wr_en        memory write strobe (also the load-port mux select)
//   mem_addr         word-aligned byte address of the write
//   mem_wdata        word being written
//   cpu_rst_n        active-low CPU reset, 1 while RUN
//   busy             load in progress
//   err              sticky: header count exceeded DEPTH
module inst_loader #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IW = $clog2(DEPTH) + 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IW-1:0] DEPTH_I   = IW'(DEPTH);
  localparam logic [15:0]   DEPTH_16  = 16'(DEPTH);
  localparam logic [16:0]   DEPTH_17  = 17'(DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DRAIN, S_FILL, S_HOLD, S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    count_lo_q, count_lo_d;
  logic [IW-1:0] eff_q, eff_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   word_q, word_d;
  logic [17:0]   drain_q, drain_d;
  logic          excess_q, excess_d;
  logic [HW-1:0] hold_q, hold_d;

  logic          byte_ready_q, byte_ready_d;
  logic          mem_wr_en_q, mem_wr_en_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          xfer;
  logic [15:0]   count_full;
  logic          over;

  assign xfer       = byte_valid & byte_ready_q;
  assign count_full = {byte_data, count_lo_q};
  assign over       = {1'b0, count_full} > DEPTH_17;

  always_comb begin
    state_d    = state_q;
    count_lo_d = count_lo_q;
    eff_d      = eff_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    drain_d    = drain_q;
    excess_d   = excess_q;
    hold_d     = hold_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          state_d    = S_HDR0;
          idx_d      = '0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          count_lo_d = byte_data;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          err_d    = over;
          excess_d = over;
          eff_d    = over ? DEPTH_I : IW'(count_full);
          // Excess words are drained as bytes: (count - DEPTH) * 4.
          drain_d  = {count_full - DEPTH_16, 2'b00};
          state_d  = (count_full == 16'd0) ? S_FILL : S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d  = idx_q + 1'b1;
        hold_d = '0;
        if (idx_d < eff_q)       state_d = S_DATA;
        else if (excess_q)       state_d = S_DRAIN;
        else if (idx_d < DEPTH_I) state_d = S_FILL;
        else                     state_d = S_HOLD;
      end
      S_DRAIN: begin
        hold_d = '0;
        if (xfer) begin
          drain_d = drain_q - 1'b1;
          if (drain_q == 18'd1) state_d = (idx_q < DEPTH_I) ? S_FILL : S_HOLD;
        end
      end
      S_FILL: begin
        idx_d  = idx_q + 1'b1;
        hold_d = '0;
        if (idx_d == DEPTH_I) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state presents, so each
    // state's outputs appear in the same cycle the state itself is occupied.
    byte_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                   (state_d == S_DATA) || (state_d == S_DRAIN);
    mem_wr_en_d  = (state_d == S_WRITE) || (state_d == S_FILL);
    mem_addr_d   = mem_wr_en_d ? 32'({idx_d, 2'b00}) : '0;
    mem_wdata_d  = (state_d == S_WRITE) ? word_d : '0;
    cpu_rst_n_d  = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE) && (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_lo_q   <= '0;
      eff_q        <= '0;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      drain_q      <= '0;
      excess_q     <= 1'b0;
      hold_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_lo_q   <= count_lo_d;
      eff_q        <= eff_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      drain_q      <= drain_d;
      excess_q     <= excess_d;
      hold_q       <= hold_d;
      byte_ready_q <= byte_ready_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader (DEPTH=256, HOLD_CYCLES=2).
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  inst_loader #(.DEPTH(256), .HOLD_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;
  int timeouts = 0;
  bit gaps = 1'b0;

  // Write/transfer monitor, sampled on the falling edge.
  int          cyc = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          xfers = 0;
  int          xfer_at_wr = 0;
  int          bad_rw = 0;
  int          bad_hold = 0;
  int          rise_cyc = 0;
  logic        prev_rn = 1'b0;
  logic        after_fill = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_valid && byte_ready) xfers <= xfers + 1;
    if (mem_wr_en) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
      xfer_at_wr <= xfers;
    end
    if (byte_ready && mem_wr_en) bad_rw <= bad_rw + 1;
    if (after_fill && byte_ready) bad_hold <= bad_hold + 1;
    if (mem_wr_en && mem_addr == 32'd1020) after_fill <= 1'b1;
    else if (!busy) after_fill <= 1'b0;
    if (cpu_rst_n && !prev_rn) rise_cyc <= cyc;
    prev_rn <= cpu_rst_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeouts++;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_prog();
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(32'h0000_0013);
    send_word(32'h0000_02B7);
    send_word(32'h0000_006F);
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!cpu_rst_n && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("run_timeout", 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] exp_word(input int mode, input int i);
    if (mode == 0) begin
      case (i)
        0: return 32'h0000_0013;
        1: return 32'h0000_02B7;
        2: return 32'h0000_006F;
        default: return 32'h0;
      endcase
    end
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // nd data words (mode selects the pattern) followed by zero fill.
  task automatic check_load(input string tag, input int b, input int nd, input int mode);
    int nw, bad_addr, bad_data, bad_gap;
    nw = wa.size() - b;
    bad_addr = 0; bad_data = 0; bad_gap = 0;
    chk({tag, "_nwrites"}, 32'(nw), 32'd256);
    for (int i = 0; i < nw && i < 256; i++) begin
      if (wa[b+i] !== 32'(i*4)) bad_addr++;
      if (i < nd) begin
        if (wd[b+i] !== exp_word(mode, i)) bad_data++;
      end else begin
        if (wd[b+i] !== 32'h0) bad_data++;
        if (i > 0 && i > nd && (wc[b+i] - wc[b+i-1]) != 1) bad_gap++;
      end
    end
    chk({tag, "_addr_seq"}, 32'(bad_addr), 32'd0);
    chk({tag, "_data"}, 32'(bad_data), 32'd0);
    chk({tag, "_fill_rate"}, 32'(bad_gap), 32'd0);
    if (nd < 256 && nw >= 256)
      chk({tag, "_hold_len"}, 32'(rise_cyc - wc[b+255]), 32'd3);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_timeouts"}, 32'(timeouts), 32'd0);
  endtask

  initial begin
    int b, x0, h0;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    // 1: reset
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ready", 32'(byte_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2: three-word program from IDLE
    b = wa.size(); h0 = bad_hold;
    pulse_start();
    chk("t2_hdr_ready", 32'(byte_ready), 32'd1);
    send_prog();
    wait_run();
    check_load("t2", b, 3, 0);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_hold_ready", 32'(bad_hold - h0), 32'd0);

    // 3: empty program, restarted from RUN
    b = wa.size();
    pulse_start();
    chk("t3_restart_cpu", 32'(cpu_rst_n), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_run();
    check_load("t3", b, 0, 0);
    chk("t3_err", 32'(err), 32'd0);

    // 4: oversize header (300 words)
    b = wa.size(); x0 = xfers;
    pulse_start();
    send_byte(8'h2C);
    send_byte(8'h01);
    @(negedge clk);
    chk("t4_err_early", 32'(err), 32'd1);
    for (int i = 0; i < 300; i++) send_word(32'hC0DE_0000 | 32'(i));
    wait_run();
    check_load("t4", b, 256, 1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_xfers", 32'(xfers - x0), 32'd1202);
    chk("t4_drained", 32'(xfers - xfer_at_wr), 32'd176);

    // 5: program with random valid gaps; start from RUN clears err
    gaps = 1'b1;
    b = wa.size(); h0 = bad_hold;
    pulse_start();
    chk("t5_err_clear", 32'(err), 32'd0);
    chk("t5_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    send_prog();
    wait_run();
    check_load("t5", b, 3, 0);
    chk("t5_hold_ready", 32'(bad_hold - h0), 32'd0);
    chk("t5_rw_overlap", 32'(bad_rw), 32'd0);
    gaps = 1'b0;

    // 6: reset in the middle of word 1, then full reload
    b = wa.size();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(32'h0000_0013);
    send_byte(8'hB7);
    send_byte(8'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_writes", 32'(wa.size() - b), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(byte_ready), 32'd0);
    chk("t6_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    b = wa.size();
    pulse_start();
    send_prog();
    wait_run();
    check_load("t6", b, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
